// File: rtl/dmem_line_responder_pkg.sv
// Shared types and constants for the data-memory line responder and its requesters.
// The line is viewed as NUM_LANES words of VEC_W bits so callers can address words directly.
package dmem_line_responder_pkg;
    localparam int LINE_BITS       = 256;
    localparam int OFF_W           = 5;
    localparam int NUM_LANES       = 8;
    localparam int VEC_W           = LINE_BITS / NUM_LANES;
    localparam int DEFAULT_LATENCY = 10;

    typedef logic [NUM_LANES-1:0][VEC_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic  write;
        line_t data;
    } req_t;

    function automatic line_t fill_line(input logic [7:0] b);
        return {(LINE_BITS/8){b}};
    endfunction
endpackage

// File: rtl/dmem_line_responder_if.sv
// Cache <-> data-memory line bus. The cache is the master, the memory the slave.
interface dmem_line_responder_if;
    import dmem_line_responder_pkg::*;

    logic        enable_i;
    logic        write_i;
    logic [31:0] addr_i;
    line_t       data_i;
    logic        ack_o;
    line_t       data_o;

    modport master (output enable_i, write_i, addr_i, data_i, input ack_o, data_o);
    modport slave  (input enable_i, write_i, addr_i, data_i, output ack_o, data_o);
endinterface

// File: rtl/dmem_line_responder_array.sv
// DEPTH_LINES x 256-bit storage: synchronous write, combinational read, never reset.
module dmem_line_responder_array
    import dmem_line_responder_pkg::*;
#(
    parameter int DEPTH_LINES = 512,
    localparam int IDX_W      = $clog2(DEPTH_LINES)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  line_t            wdata,
    output line_t            rdata
);
    line_t mem [DEPTH_LINES];

    always_ff @(posedge clk_i) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/dmem_line_responder.sv
// Backing line store for the data cache: one line read/write per request,
// acknowledged with a single-cycle pulse LATENCY edges after acceptance.
module dmem_line_responder
    import dmem_line_responder_pkg::*;
#(
    parameter int LATENCY     = DEFAULT_LATENCY,
    parameter int DEPTH_LINES = 512
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dmem_line_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    line_t            rdata_q;
    logic [IDX_W-1:0] idx_q;
    req_t             req_q;
    logic             accept, complete;
    line_t            rd_line;

    // Every latency, including 1, passes through BUSY so the ack always lands
    // LATENCY edges after acceptance and the abandon check applies uniformly.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable_i) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!bus.enable_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    complete = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            if (complete && !req_q.write) rdata_q <= rd_line;
        end
    end

    // Request copies only matter once accepted, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            idx_q       <= bus.addr_i[OFF_W +: IDX_W];
            req_q.write <= bus.write_i;
            req_q.data  <= bus.data_i;
        end
    end

    dmem_line_responder_array #(.DEPTH_LINES(DEPTH_LINES)) u_array (
        .clk_i (clk_i),
        .we    (complete && req_q.write),
        .idx   (idx_q),
        .wdata (req_q.data),
        .rdata (rd_line)
    );

    assign bus.ack_o  = ack_q;
    assign bus.data_o = rdata_q;
endmodule

// File: tb/tb_dmem_line_responder.sv
// Randomized scoreboard bench for dmem_line_responder (LATENCY=10 and LATENCY=1 instances).
module tb_dmem_line_responder;
    import dmem_line_responder_pkg::*;

    localparam int LAT   = 10;
    localparam int DEPTH = 512;

    typedef struct {
        logic  rd;
        line_t data;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i, rst1_i;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;

    exp_t  q0[$], q1[$];
    line_t model[int];
    line_t last_rd[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_line_responder_if bus ();
    dmem_line_responder_if bus1 ();

    dmem_line_responder #(.LATENCY(LAT), .DEPTH_LINES(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .bus(bus));
    dmem_line_responder #(.LATENCY(1), .DEPTH_LINES(DEPTH)) dut1 (
        .clk_i(clk), .rst_i(rst1_i), .bus(bus1));

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic line_t rnd_line();
        line_t l;
        for (int i = 0; i < NUM_LANES; i++) l[i] = $urandom;
        return l;
    endfunction

    function automatic logic ack_of(input int w);
        return (w != 0) ? bus1.ack_o : bus.ack_o;
    endfunction

    function automatic line_t dout_of(input int w);
        return (w != 0) ? bus1.data_o : bus.data_o;
    endfunction

    task automatic drive(input int w, input logic en, input logic wr, input logic [31:0] a, input line_t d);
        if (w == 0) begin
            bus.enable_i = en; bus.write_i = wr; bus.addr_i = a; bus.data_i = d;
        end else begin
            bus1.enable_i = en; bus1.write_i = wr; bus1.addr_i = a; bus1.data_i = d;
        end
    endtask

    // Called at a negedge with the DUT idle (or in its ack cycle when skip=1).
    task automatic req(input int w, input logic wr, input logic [31:0] a, input line_t d,
                       input bit hold, input bit skip);
        exp_t e;
        int   key, lat;
        bit   got;
        lat = (w != 0) ? 1 : LAT;
        key = w * 4096 + int'((a >> OFF_W) % DEPTH);
        drive(w, 1'b1, wr, a, d);
        e.rd  = !wr;
        e.cyc = cyc + 1 + int'(skip) + lat;
        if (wr) begin
            model[key] = d;
            e.data = last_rd[w];
        end else begin
            e.data = model[key];
            last_rd[w] = model[key];
        end
        if (w == 0) q0.push_back(e); else q1.push_back(e);
        got = 1'b0;
        for (int i = 0; i < lat + 6 && !got; i++) begin
            @(negedge clk);
            got = ack_of(w);
        end
        if (!got) chk("ack_timeout", {255'd0, got}, 256'd1);
        if (!hold) begin
            drive(w, 1'b0, wr, a, d);
            @(negedge clk);
        end
    endtask

    task automatic abort_wr(input logic [31:0] a, input line_t d, input int n_in);
        int acks = 0;
        drive(0, 1'b1, 1'b1, a, d);
        repeat (n_in) @(negedge clk);
        drive(0, 1'b0, 1'b1, a, d);
        repeat (LAT + 4) begin
            @(negedge clk);
            if (bus.ack_o) acks++;
        end
        chk("abort_no_ack", 256'(acks), 256'd0);
    endtask

    task automatic rst_mid(input int w, input logic wr, input logic [31:0] a, input line_t d, input int n_in);
        int acks = 0;
        drive(w, 1'b1, wr, a, d);
        repeat (n_in) @(negedge clk);
        if (w == 0) rst_i = 1'b0; else rst1_i = 1'b0;
        drive(w, 1'b0, wr, a, d);
        repeat (3) begin
            @(negedge clk);
            if (ack_of(w)) acks++;
        end
        chk("rst_mid_no_ack", 256'(acks), 256'd0);
        chk("rst_mid_data_o", dout_of(w), 256'd0);
        last_rd[w] = '0;
        if (w == 0) rst_i = 1'b1; else rst1_i = 1'b1;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (ack_of(w)) acks++;
        end
        chk("rst_mid_no_late_ack", 256'(acks), 256'd0);
    endtask

    initial begin
        bit    hold;
        line_t old40;
        rst_i = 1'b0; rst1_i = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0, '0);
        drive(1, 1'b1, 1'b0, 32'h0, '0);
        last_rd[0] = '0; last_rd[1] = '0;

        fork
            forever begin : mon0
                exp_t e0;
                @(negedge clk);
                if (bus.ack_o === 1'b1) begin
                    if (q0.size() == 0) chk("dut0_unexpected_ack", {255'd0, bus.ack_o}, 256'd0);
                    else begin
                        e0 = q0.pop_front();
                        chk("dut0_ack_cycle", 256'(cyc), 256'(e0.cyc));
                        chk(e0.rd ? "dut0_read_data" : "dut0_data_o_held", bus.data_o, e0.data);
                    end
                end
            end
            forever begin : mon1
                exp_t e1;
                @(negedge clk);
                if (bus1.ack_o === 1'b1) begin
                    if (q1.size() == 0) chk("dut1_unexpected_ack", {255'd0, bus1.ack_o}, 256'd0);
                    else begin
                        e1 = q1.pop_front();
                        chk("dut1_ack_cycle", 256'(cyc), 256'(e1.cyc));
                        chk(e1.rd ? "dut1_read_data" : "dut1_data_o_held", bus1.data_o, e1.data);
                    end
                end
            end
        join_none

        // Reset held with enable asserted: nothing accepted, outputs zero.
        repeat (4) begin
            @(negedge clk);
            chk("rst_ack", {255'd0, bus.ack_o}, 256'd0);
            chk("rst_data_o", bus.data_o, 256'd0);
        end
        drive(0, 1'b0, 1'b0, 32'h0, '0);
        drive(1, 1'b0, 1'b0, 32'h0, '0);
        rst_i = 1'b1; rst1_i = 1'b1;
        repeat (2) @(negedge clk);

        // Write then read the same line through a different byte offset.
        req(0, 1'b1, 32'h0000_0400, fill_line(8'hA5), 1'b0, 1'b0);
        req(0, 1'b0, 32'h0000_041C, '0, 1'b0, 1'b0);

        // Abandoned write leaves the old contents.
        old40 = fill_line(8'h3C);
        req(0, 1'b1, 32'h0000_0040, old40, 1'b0, 1'b0);
        abort_wr(32'h0000_0040, fill_line(8'hFF), 3);
        req(0, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);

        // Index aliasing above log2(DEPTH).
        req(0, 1'b1, 32'h0000_4000, fill_line(8'h5A), 1'b0, 1'b0);
        req(0, 1'b0, 32'h0000_0000, '0, 1'b0, 1'b0);

        // Enable held through the ack cycle.
        req(0, 1'b1, 32'h0000_0080, rnd_line(), 1'b1, 1'b0);
        req(0, 1'b0, 32'h0000_0080, '0, 1'b0, 1'b1);

        // Reset in the middle of a write loses it.
        rst_mid(0, 1'b1, 32'h0000_0080, rnd_line(), 4);
        req(0, 1'b0, 32'h0000_0080, '0, 1'b0, 1'b0);

        // Randomized traffic over a small aliased pool of lines.
        for (int p = 0; p < 8; p++) req(0, 1'b1, 32'(p) << OFF_W, rnd_line(), 1'b0, 1'b0);
        hold = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            bit          h, wr;
            a  = (32'($urandom_range(0, 7)) << OFF_W) | (32'($urandom_range(0, 3)) << 14)
               | 32'($urandom_range(0, 31));
            wr = $urandom_range(0, 1) != 0;
            h  = ($urandom_range(0, 3) == 0) && (n != 39);
            req(0, wr, a, rnd_line(), h, hold);
            hold = h;
            if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // LATENCY=1 instance: ack one edge after acceptance, reset aborts BUSY.
        req(1, 1'b1, 32'h0000_0020, fill_line(8'hC3), 1'b0, 1'b0);
        req(1, 1'b0, 32'h0000_0020, '0, 1'b0, 1'b0);
        rst_mid(1, 1'b0, 32'h0000_0020, '0, 1);
        req(1, 1'b0, 32'h0000_0020, '0, 1'b1, 1'b0);
        req(1, 1'b1, 32'h0000_0020, rnd_line(), 1'b0, 1'b1);

        repeat (4) @(negedge clk);
        chk("dut0_queue_empty", 256'(q0.size()), 256'd0);
        chk("dut1_queue_empty", 256'(q1.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
